mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported, multi-cycle unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
- Sequences each access through a fixed latency and returns data with a one-cycle ready pulse.
- Drives a stall request into the pipeline hazard logic while any requester is waiting.
- Sits between the IF/MEM stages and the backing memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory needs per access (legal range 1..15).
- STARVE_MAX, 4, consecutive DM grants allowed while IF waits before IF is forced to win.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  grant enable; no new grants while low
- if_req_i  in  1  IF read request, held until if_ready_o
- if_addr_i  in  ADDR_W  IF byte address
- if_data_o  out  DATA_W  IF read data, valid when if_ready_o
- if_ready_o  out  1  one-cycle completion pulse for IF
- dm_req_i  in  1  DM request, held until dm_ready_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  DM byte address
- dm_wdata_i  in  DATA_W  DM write data
- dm_rdata_o  out  DATA_W  DM read data, valid when dm_ready_o on a read
- dm_ready_o  out  1  one-cycle completion pulse for DM
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address (latched)
- mem_wdata_o  out  DATA_W  memory write data (latched)
- mem_rdata_i  in  DATA_W  memory read data, sampled on the last BUSY cycle
- stall_o  out  1  pipeline stall request

Behaviour:
- Reset values: state=IDLE, all outputs 0, latency count 0, starve count 0, latched owner/address/data 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if start_i & (if_req_i | dm_req_i), grant one owner.
  - Latch owner, address, we and wdata.
  - Load count = MEM_LAT-1 and move to BUSY.
- Grant priority: DM wins over IF, unless IF is waiting and starve count == STARVE_MAX; then IF wins.
- Starve count:
  - +1 on every DM grant while if_req_i is high, saturating at STARVE_MAX.
  - Cleared on every IF grant.
- BUSY: mem_en_o=1; mem_we_o, mem_addr_o and mem_wdata_o come from the latched values.
  - count decrements each cycle.
  - At count==0 on a read, capture mem_rdata_i into the owner's data register, then move to RESP.
- RESP: the owner's ready_o=1 for exactly one cycle, mem_en_o=0, no grant in this cycle, then IDLE.
- Latency: request first seen in IDLE in cycle c → ready high in cycle c+MEM_LAT+1. Back-to-back accesses occupy MEM_LAT+2 cycles each.
- if_data_o and dm_rdata_o hold their last captured value. A DM write pulses dm_ready_o and leaves dm_rdata_o unchanged.
- stall_o (combinational) = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o).
- Boundary conditions:
  - start_i falling mid-access: the in-flight access completes normally; no further grants.
  - rst_i in any state: the next cycle is IDLE with mem_en_o=0; no ready pulse for the aborted access.
  - A request withdrawn before grant is ignored. A request withdrawn after grant still completes; its ready pulse is harmless.
  - Simultaneous IF and DM requests with starve count < STARVE_MAX: DM is granted.
  - MEM_LAT=1: BUSY lasts exactly one cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, three extra outputs are added:
  - if_grant_cnt_o (32): saturating count of IF grants.
  - dm_grant_cnt_o (32): saturating count of DM grants.
  - stall_cnt_o (32): cycles with stall_o=1.
  - All three are cleared by rst_i.
- When undefined, these ports and counters do not exist. Arbitration and timing are identical either way.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding (ARB_IDLE, ARB_BUSY, ARB_RESP);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - default width constants.
- One sub-module, mem_lat_timer: loadable down-counter with a zero flag and synchronous reset.

Test Plan:
- Reset, MEM_LAT=2; IF reads 0x10 in cycle 5 with mem_rdata_i=0xDEADBEEF → mem_en_o high in cycles 6–7, if_ready_o high only in cycle 8, if_data_o=0xDEADBEEF, stall_o high in cycles 5–7.
- IF and DM both request in the same cycle; DM writes 0x5 to 0x04 → DM granted first (mem_we_o=1, mem_addr_o=0x04); IF ready 4 cycles after DM ready; dm_rdata_o unchanged.
- STARVE_MAX=4; DM requests continuously and IF requests continuously → 4 DM grants, then 1 IF grant, then the pattern repeats.
- rst_i asserted in the second BUSY cycle → mem_en_o=0 next cycle, no ready pulse, FSM in IDLE; a new request then completes normally.
- start_i deasserted mid-BUSY → the current access completes with a ready pulse; a pending second request gets no grant until start_i=1.
- With ARB_PERF_CNT_EN, 3 IF and 2 DM accesses → if_grant_cnt_o=3, dm_grant_cnt_o=2, stall_cnt_o equals the bench-counted stall cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared state/owner encodings and default widths for the memory port arbiter.
package arb_pkg;
    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_MEM_LAT    = 2;
    localparam int ARB_STARVE_MAX = 4;
    localparam int ARB_CNT_W      = 4;
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/mem_lat_timer.sv
// mem_lat_timer: loadable down-counter with a zero flag and synchronous reset.
module mem_lat_timer
    import arb_pkg::*;
#(
    parameter int W = ARB_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt <= '0;
        else if (load_i) cnt <= val_i;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero_o = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/DM arbiter for a single-ported multi-cycle memory with starvation guard.
// Optional grant/stall performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MEM_LAT    = ARB_MEM_LAT,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_grant_cnt_o,
    output logic [31:0]       dm_grant_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [1:0]        state;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_data_q;
    logic [SW-1:0]     starve;
    logic              zero;
    logic              grant;
    logic              pick_if;
    assign grant   = state == ARB_IDLE && start_i && (if_req_i || dm_req_i);
    // DM normally wins; IF is forced through once it has lost STARVE_MAX times in a row
    assign pick_if = if_req_i && (!dm_req_i || starve == SW'(STARVE_MAX));
    mem_lat_timer #(.W(ARB_CNT_W)) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (grant),
        .val_i  (ARB_CNT_W'(MEM_LAT - 1)),
        .zero_o (zero)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            dm_data_q <= '0;
            starve    <= '0;
        end else if (grant) begin
            state   <= ARB_BUSY;
            owner   <= pick_if ? OWN_IF : OWN_DM;
            we_q    <= !pick_if && dm_we_i;
            addr_q  <= pick_if ? if_addr_i : dm_addr_i;
            wdata_q <= pick_if ? '0 : dm_wdata_i;
            starve  <= pick_if ? '0 : (if_req_i && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
        end else if (state == ARB_BUSY && zero) begin
            state <= ARB_RESP;
            if (!we_q && owner == OWN_IF) if_data_q <= mem_rdata_i;
            if (!we_q && owner == OWN_DM) dm_data_q <= mem_rdata_i;
        end else if (state != ARB_BUSY) begin
            state <= ARB_IDLE;
        end
    end
    assign mem_en_o    = state == ARB_BUSY;
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ready_o  = state == ARB_RESP && owner == OWN_IF;
    assign dm_ready_o  = state == ARB_RESP && owner == OWN_DM;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_data_q;
    assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_grant_cnt_o <= '0;
            dm_grant_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            if (grant && pick_if) if_grant_cnt_o <= sat_inc32(if_grant_cnt_o);
            if (grant && !pick_if) dm_grant_cnt_o <= sat_inc32(dm_grant_cnt_o);
            if (stall_o) stall_cnt_o <= sat_inc32(stall_cnt_o);
        end
    end
`endif
endmodule
